cache_nwsa: RTL and testbench

//  Parametrised N-way set-associative write-back cache between the CPU port and main memory; generalises
//  the 2-way 16b-addr/8b-data cache. Adds configurable ways/sets/block length, split CPU data buses
//  (no inout), a memory handshake that tolerates wait states, and a selectable write-miss policy.

---
 rtl/cache_pkg.sv | 49 ++++
 rtl/cache_way_ram.sv | 55 +++++
 rtl/cache_nwsa.sv | 238 +++++++++++++++++++++++
 tb/tb_cache_nwsa.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and address-field helpers for the N-way set-associative cache.
// Field widths derive from block and set geometry.
package cache_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WB,
        S_FILL,
        S_WAROUND,
        S_DONE
    } state_t;

    function automatic int off_bits(input int beats);
        return $clog2(beats);
    endfunction

    function automatic int idx_bits(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_bits(input int aw, input int beats, input int sets);
        return aw - $clog2(beats) - $clog2(sets);
    endfunction

    function automatic int way_bits(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

    function automatic logic [31:0] field(input logic [31:0] a, input int lsb, input int w);
        logic [31:0] m;
        m = (32'h1 << w) - 32'h1;
        return (a >> lsb) & m;
    endfunction

    function automatic logic [31:0] offset_of(input logic [31:0] a, input int beats);
        return field(a, 0, $clog2(beats));
    endfunction

    function automatic logic [31:0] index_of(input logic [31:0] a, input int beats,
                                             input int sets);
        return field(a, $clog2(beats), $clog2(sets));
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] a, input int beats,
                                           input int sets);
        return a >> ($clog2(beats) + $clog2(sets));
    endfunction

endpackage

// File: rtl/cache_way_ram.sv
// One cache way: tag/valid/dirty per set plus block data.
// Asynchronous read, synchronous write; only valid/dirty are reset.
module cache_way_ram #(
    parameter int SETS        = 16,
    parameter int BLOCK_BEATS = 4,
    parameter int IDX_W       = 4,
    parameter int OFF_W       = 2,
    parameter int TAG_W       = 10,
    parameter int DATA_W      = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [IDX_W-1:0]  i_idx,
    input  logic [OFF_W-1:0]  i_off,
    output logic [TAG_W-1:0]  o_tag,
    output logic              o_valid,
    output logic              o_dirty,
    output logic [DATA_W-1:0] o_rdata,
    input  logic              i_data_we,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_fill_done,
    input  logic [TAG_W-1:0]  i_tag,
    input  logic              i_set_dirty
);

    logic [TAG_W-1:0]       r_tag  [SETS];
    logic [DATA_W-1:0]      r_data [SETS*BLOCK_BEATS];
    logic [SETS-1:0]        r_valid;
    logic [SETS-1:0]        r_dirty;
    logic [IDX_W+OFF_W-1:0] w_addr;

    assign w_addr  = {i_idx, i_off};
    assign o_tag   = r_tag[i_idx];
    assign o_valid = r_valid[i_idx];
    assign o_dirty = r_dirty[i_idx];
    assign o_rdata = r_data[w_addr];

    always_ff @(posedge clock) begin
        if (i_data_we) r_data[w_addr] <= i_wdata;
        if (i_fill_done) r_tag[i_idx] <= i_tag;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (i_fill_done) begin
            r_valid[i_idx] <= 1'b1;
            r_dirty[i_idx] <= 1'b0;
        end else if (i_set_dirty) begin
            r_dirty[i_idx] <= 1'b1;
        end
    end

endmodule

// File: rtl/cache_nwsa.sv
// N-way set-associative write-back cache with burst refill/write-back,
// wait-state tolerant memory handshake and selectable write-miss policy.
module cache_nwsa
    import cache_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 8,
    parameter int WAYS        = 2,
    parameter int SETS        = 16,
    parameter int BLOCK_BEATS = 4,
    parameter bit WRITE_ALLOC = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr_cpu,
    input  logic              rd_cpu,
    input  logic              wr_cpu,
    input  logic [DATA_W-1:0] wdata_cpu,
    output logic [DATA_W-1:0] rdata_cpu,
    output logic              stall_cpu,
    output logic [ADDR_W-1:0] addr_mem,
    output logic              rd_mem,
    output logic              wr_mem,
    output logic [DATA_W-1:0] wdata_mem,
    input  logic [DATA_W-1:0] rdata_mem,
    input  logic              ready_mem
);

    localparam int OFF_W = off_bits(BLOCK_BEATS);
    localparam int IDX_W = idx_bits(SETS);
    localparam int TAG_W = tag_bits(ADDR_W, BLOCK_BEATS, SETS);
    localparam int WAY_W = way_bits(WAYS);
    localparam logic [OFF_W-1:0] LAST = OFF_W'(BLOCK_BEATS - 1);

    state_t            r_state;
    state_t            w_next;
    logic [OFF_W-1:0]  r_beat;
    logic [WAY_W-1:0]  r_vway;
    logic              r_around;
    logic [ADDR_W-1:0] r_req_addr;

    logic [TAG_W-1:0]  w_tag;
    logic [IDX_W-1:0]  w_idx;
    logic [OFF_W-1:0]  w_off;
    logic              w_rd;
    logic              w_wr;
    logic              w_req;

    logic [TAG_W-1:0]  w_way_tag   [WAYS];
    logic [DATA_W-1:0] w_way_rdata [WAYS];
    logic [WAYS-1:0]   w_way_valid;
    logic [WAYS-1:0]   w_way_dirty;
    logic [WAYS-1:0]   w_way_hit;
    logic [WAYS-1:0]   w_data_we;
    logic [WAYS-1:0]   w_fill_done;
    logic [WAYS-1:0]   w_set_dirty;
    logic [OFF_W-1:0]  w_ram_off;
    logic [DATA_W-1:0] w_ram_wdata;

    logic              w_hit;
    logic              w_any_inv;
    logic [WAY_W-1:0]  w_hit_way;
    logic [WAY_W-1:0]  w_inv_way;
    logic [WAY_W-1:0]  w_victim;
    logic [WAY_W-1:0]  w_ptr;
    logic              w_xfer;
    logic              w_last;
    logic              w_fill_any;

    assign w_tag = TAG_W'(tag_of(32'(addr_cpu), BLOCK_BEATS, SETS));
    assign w_idx = IDX_W'(index_of(32'(addr_cpu), BLOCK_BEATS, SETS));
    assign w_off = OFF_W'(offset_of(32'(addr_cpu), BLOCK_BEATS));

    // A simultaneous read and write is served as a read.
    assign w_rd  = rd_cpu;
    assign w_wr  = wr_cpu & ~rd_cpu;
    assign w_req = w_rd | w_wr;

    for (genvar g = 0; g < WAYS; g++) begin : g_way
        cache_way_ram #(
            .SETS        (SETS),
            .BLOCK_BEATS (BLOCK_BEATS),
            .IDX_W       (IDX_W),
            .OFF_W       (OFF_W),
            .TAG_W       (TAG_W),
            .DATA_W      (DATA_W)
        ) u_ram (
            .clock       (clock),
            .reset       (reset),
            .i_idx       (w_idx),
            .i_off       (w_ram_off),
            .o_tag       (w_way_tag[g]),
            .o_valid     (w_way_valid[g]),
            .o_dirty     (w_way_dirty[g]),
            .o_rdata     (w_way_rdata[g]),
            .i_data_we   (w_data_we[g]),
            .i_wdata     (w_ram_wdata),
            .i_fill_done (w_fill_done[g]),
            .i_tag       (w_tag),
            .i_set_dirty (w_set_dirty[g])
        );
        assign w_way_hit[g] = w_way_valid[g] && (w_way_tag[g] == w_tag);
    end

    always_comb begin
        w_hit_way = '0;
        w_inv_way = '0;
        w_any_inv = 1'b0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (w_way_hit[w]) w_hit_way = WAY_W'(w);
            if (!w_way_valid[w]) begin
                w_inv_way = WAY_W'(w);
                w_any_inv = 1'b1;
            end
        end
    end

    assign w_hit      = |w_way_hit;
    assign w_victim   = w_any_inv ? w_inv_way : w_ptr;
    assign w_xfer     = (rd_mem | wr_mem) & ready_mem;
    assign w_last     = (r_beat == LAST);
    assign w_fill_any = (r_state == S_FILL) && ready_mem && w_last;

    if (WAYS > 1) begin : g_rr
        logic [WAY_W-1:0] r_ptr [SETS];
        assign w_ptr = r_ptr[w_idx];
        always_ff @(posedge clock) begin
            if (reset) begin
                for (int s = 0; s < SETS; s++) r_ptr[s] <= '0;
            end else if (w_fill_any) begin
                r_ptr[w_idx] <= r_ptr[w_idx] + WAY_W'(1);
            end
        end
    end else begin : g_dm
        assign w_ptr = '0;
    end

    always_comb begin
        w_next      = r_state;
        stall_cpu   = 1'b0;
        rd_mem      = 1'b0;
        wr_mem      = 1'b0;
        addr_mem    = '0;
        wdata_mem   = '0;
        rdata_cpu   = '0;
        w_ram_off   = w_off;
        w_ram_wdata = wdata_cpu;
        w_data_we   = '0;
        w_fill_done = '0;
        w_set_dirty = '0;
        unique case (r_state)
            S_IDLE: begin
                if (w_req && w_hit) begin
                    if (w_rd) begin
                        rdata_cpu = w_way_rdata[w_hit_way];
                    end else begin
                        w_data_we[w_hit_way]   = 1'b1;
                        w_set_dirty[w_hit_way] = 1'b1;
                    end
                end else if (w_req) begin
                    stall_cpu = 1'b1;
                    if (w_wr && !WRITE_ALLOC)
                        w_next = S_WAROUND;
                    else if (w_way_valid[w_victim] && w_way_dirty[w_victim])
                        w_next = S_WB;
                    else
                        w_next = S_FILL;
                end
            end
            S_WB: begin
                stall_cpu = 1'b1;
                wr_mem    = 1'b1;
                w_ram_off = r_beat;
                addr_mem  = {w_way_tag[r_vway], w_idx, r_beat};
                wdata_mem = w_way_rdata[r_vway];
                if (w_xfer && w_last) w_next = S_FILL;
            end
            S_FILL: begin
                stall_cpu   = 1'b1;
                rd_mem      = 1'b1;
                w_ram_off   = r_beat;
                w_ram_wdata = rdata_mem;
                addr_mem    = {w_tag, w_idx, r_beat};
                if (ready_mem) w_data_we[r_vway] = 1'b1;
                if (ready_mem && w_last) begin
                    w_fill_done[r_vway] = 1'b1;
                    w_next = S_DONE;
                end
            end
            S_WAROUND: begin
                stall_cpu = 1'b1;
                wr_mem    = 1'b1;
                addr_mem  = addr_cpu;
                wdata_mem = wdata_cpu;
                if (ready_mem) w_next = S_DONE;
            end
            S_DONE: begin
                w_next = S_IDLE;
                if (!r_around && w_rd) begin
                    rdata_cpu = w_way_rdata[r_vway];
                end else if (!r_around && w_wr) begin
                    w_data_we[r_vway]   = 1'b1;
                    w_set_dirty[r_vway] = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_beat   <= '0;
            r_vway   <= '0;
            r_around <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE) begin
                r_beat     <= '0;
                r_vway     <= w_victim;
                r_around   <= (w_next == S_WAROUND);
                r_req_addr <= addr_cpu;
            end else if (w_xfer && (r_state == S_WB || r_state == S_FILL)) begin
                r_beat <= r_beat + OFF_W'(1);
            end
        end
    end

    // The CPU must hold its request steady until the miss is resolved.
    always_ff @(posedge clock) begin
        if (!reset) begin
            assert (!(rd_cpu && wr_cpu));
            if (r_state == S_WB || r_state == S_FILL || r_state == S_WAROUND)
                assert (w_req && (addr_cpu == r_req_addr));
        end
    end

endmodule

// File: tb/tb_cache_nwsa.sv
// Scoreboard bench: stimulus queues expected CPU completions and memory beats,
// monitors pop and compare as the cache presents them.
module tb_cache_nwsa;

    typedef struct {
        bit         rd;
        logic [7:0] data;
        int         stall;
    } cpu_exp_t;

    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  data;
    } beat_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        sel   = 1'b0;
    logic        rd_cpu = 1'b0;
    logic        wr_cpu = 1'b0;
    logic [15:0] addr_cpu = '0;
    logic [7:0]  wdata_cpu = '0;
    logic        ready_mem = 1'b1;

    logic        rd_a, wr_a, rd_b, wr_b;
    logic [7:0]  a_rdata, b_rdata, a_wdata_mem, b_wdata_mem, a_rdata_mem, b_rdata_mem;
    logic        a_stall, b_stall, a_rd_mem, b_rd_mem, a_wr_mem, b_wr_mem;
    logic [15:0] a_addr_mem, b_addr_mem;

    logic        m_stall, m_rd_mem, m_wr_mem;
    logic [7:0]  m_rdata, m_wdata_mem;
    logic [15:0] m_addr_mem;

    logic [7:0]  mem [0:65535];

    cpu_exp_t    cpu_q [$];
    beat_t       beat_q [$];
    int          errors = 0;
    int          checks = 0;
    int          cpu_cnt = 0;

    always #5 clock = ~clock;

    assign rd_a = rd_cpu & ~sel;
    assign wr_a = wr_cpu & ~sel;
    assign rd_b = rd_cpu & sel;
    assign wr_b = wr_cpu & sel;
    assign a_rdata_mem = mem[a_addr_mem];
    assign b_rdata_mem = mem[b_addr_mem];

    assign m_stall     = sel ? b_stall     : a_stall;
    assign m_rd_mem    = sel ? b_rd_mem    : a_rd_mem;
    assign m_wr_mem    = sel ? b_wr_mem    : a_wr_mem;
    assign m_rdata     = sel ? b_rdata     : a_rdata;
    assign m_wdata_mem = sel ? b_wdata_mem : a_wdata_mem;
    assign m_addr_mem  = sel ? b_addr_mem  : a_addr_mem;

    cache_nwsa #(.WRITE_ALLOC(1'b1)) dut (
        .clock     (clock),
        .reset     (reset),
        .addr_cpu  (addr_cpu),
        .rd_cpu    (rd_a),
        .wr_cpu    (wr_a),
        .wdata_cpu (wdata_cpu),
        .rdata_cpu (a_rdata),
        .stall_cpu (a_stall),
        .addr_mem  (a_addr_mem),
        .rd_mem    (a_rd_mem),
        .wr_mem    (a_wr_mem),
        .wdata_mem (a_wdata_mem),
        .rdata_mem (a_rdata_mem),
        .ready_mem (ready_mem)
    );

    cache_nwsa #(.WRITE_ALLOC(1'b0)) dut_wa (
        .clock     (clock),
        .reset     (reset),
        .addr_cpu  (addr_cpu),
        .rd_cpu    (rd_b),
        .wr_cpu    (wr_b),
        .wdata_cpu (wdata_cpu),
        .rdata_cpu (b_rdata),
        .stall_cpu (b_stall),
        .addr_mem  (b_addr_mem),
        .rd_mem    (b_rd_mem),
        .wr_mem    (b_wr_mem),
        .wdata_mem (b_wdata_mem),
        .rdata_mem (b_rdata_mem),
        .ready_mem (ready_mem)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Main memory model with preloaded directed contents.
    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h0090] = 8'h11; mem[16'h0091] = 8'h22;
        mem[16'h0092] = 8'h33; mem[16'h0093] = 8'h44;
        mem[16'h4090] = 8'hA1; mem[16'h4091] = 8'hA2;
        mem[16'h4092] = 8'hA3; mem[16'h4093] = 8'hA4;
        mem[16'h8090] = 8'hB1; mem[16'h8091] = 8'hB2;
        mem[16'h8092] = 8'hB3; mem[16'h8093] = 8'hB4;
        mem[16'h0160] = 8'hC0; mem[16'h0161] = 8'hC1;
        mem[16'h0162] = 8'hC2; mem[16'h0163] = 8'hC3;
        mem[16'h0260] = 8'hD1; mem[16'h0261] = 8'hD2;
        mem[16'h0262] = 8'hD3; mem[16'h0263] = 8'hD4;
        forever begin
            @(posedge clock);
            if (a_wr_mem && ready_mem) mem[a_addr_mem] = a_wdata_mem;
            if (b_wr_mem && ready_mem) mem[b_addr_mem] = b_wdata_mem;
        end
    end

    // CPU-side monitor: counts stall cycles and checks each completion.
    initial begin
        cpu_exp_t e;
        forever begin
            @(negedge clock);
            if (reset || !(rd_cpu || wr_cpu)) begin
                cpu_cnt = 0;
            end else if (m_stall) begin
                cpu_cnt++;
            end else begin
                if (cpu_q.size() != 0) e = cpu_q.pop_front();
                else e = '{rd: 1'b1, data: 8'hxx, stall: -1};
                chk("stall_cycles", cpu_cnt, e.stall);
                if (e.rd) chk("rdata_cpu", m_rdata, e.data);
                cpu_cnt = 0;
            end
        end
    end

    // Memory-side monitor: every accepted beat must match the next expected one.
    initial begin
        beat_t b;
        forever begin
            @(negedge clock);
            if (!reset && (m_rd_mem || m_wr_mem) && ready_mem) begin
                if (beat_q.size() != 0) b = beat_q.pop_front();
                else b = '{wr: ~m_wr_mem, addr: 16'hFFFF, data: 8'hFF};
                chk("beat_kind", m_wr_mem, b.wr);
                chk("beat_addr", m_addr_mem, b.addr);
                if (b.wr) chk("beat_wdata", m_wdata_mem, b.data);
            end
        end
    end

    task automatic push_fill(input logic [15:0] base);
        for (int i = 0; i < 4; i++)
            beat_q.push_back('{wr: 1'b0, addr: base + 16'(i), data: 8'h00});
    endtask

    task automatic push_wb(input logic [15:0] base, input logic [31:0] d);
        for (int i = 0; i < 4; i++)
            beat_q.push_back('{wr: 1'b1, addr: base + 16'(i), data: d[31-8*i -: 8]});
    endtask

    task automatic access(input bit w, input logic [15:0] a, input logic [7:0] d,
                          input logic [7:0] exp_d, input int exp_stall);
        int n;
        cpu_q.push_back('{rd: !w, data: exp_d, stall: exp_stall});
        rd_cpu = !w;
        wr_cpu = w;
        addr_cpu = a;
        wdata_cpu = d;
        n = 0;
        forever begin
            @(negedge clock);
            if (!m_stall || n > 100) break;
            n++;
        end
        if (n > 100) chk("access_timeout", n, 0);
        @(posedge clock);
        #1;
        rd_cpu = 1'b0;
        wr_cpu = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int seen;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_stall", m_stall, 0);
        chk("rst_rd_mem", m_rd_mem, 0);
        chk("rst_wr_mem", m_wr_mem, 0);
        chk("rst_addr_mem", m_addr_mem, 0);
        chk("rst_wdata_mem", m_wdata_mem, 0);
        chk("rst_rdata_cpu", m_rdata, 0);
        @(posedge clock);
        #1 reset = 1'b0;

        // Clean read miss, then hit in the filled block.
        push_fill(16'h0090);
        access(1'b0, 16'h0093, 8'h00, 8'h44, 5);
        access(1'b0, 16'h0091, 8'h00, 8'h22, 0);

        // Write hit, then read back.
        access(1'b1, 16'h0093, 8'h35, 8'h00, 0);
        access(1'b0, 16'h0093, 8'h00, 8'h35, 0);

        // Fill way1, then evict dirty way0 by round-robin.
        push_fill(16'h4090);
        access(1'b0, 16'h4093, 8'h00, 8'hA4, 5);
        push_wb(16'h0090, 32'h11223335);
        push_fill(16'h8090);
        access(1'b0, 16'h8093, 8'h00, 8'hB4, 9);
        chk("wb_mem_0093", mem[16'h0093], 8'h35);
        access(1'b0, 16'h4091, 8'h00, 8'hA2, 0);

        // Read miss with three wait states after the first beat.
        push_fill(16'h0160);
        fork
            access(1'b0, 16'h0161, 8'h00, 8'hC1, 8);
            begin
                for (int k = 0; k < 50; k++) begin
                    @(negedge clock);
                    if (m_rd_mem && ready_mem) break;
                end
                @(posedge clock);
                #1 ready_mem = 1'b0;
                repeat (3) begin
                    @(negedge clock);
                    chk("hold_addr", m_addr_mem, 16'h0161);
                    chk("hold_rd", m_rd_mem, 1);
                end
                @(posedge clock);
                #1 ready_mem = 1'b1;
            end
        join

        // Write-around instance.
        sel = 1'b1;
        beat_q.push_back('{wr: 1'b1, addr: 16'h1234, data: 8'h5A});
        access(1'b1, 16'h1234, 8'h5A, 8'h00, 2);
        push_fill(16'h1234);
        access(1'b0, 16'h1234, 8'h00, 8'h5A, 5);
        sel = 1'b0;

        // Reset in the middle of a fill.
        beat_q.push_back('{wr: 1'b0, addr: 16'h0260, data: 8'h00});
        beat_q.push_back('{wr: 1'b0, addr: 16'h0261, data: 8'h00});
        rd_cpu = 1'b1;
        addr_cpu = 16'h0261;
        seen = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clock);
            if (m_rd_mem && ready_mem) seen++;
            if (seen == 2) break;
        end
        chk("t6_beats_seen", seen, 2);
        @(posedge clock);
        #1;
        reset = 1'b1;
        rd_cpu = 1'b0;
        @(posedge clock);
        @(negedge clock);
        chk("mid_rst_rd_mem", m_rd_mem, 0);
        chk("mid_rst_wr_mem", m_wr_mem, 0);
        chk("mid_rst_stall", m_stall, 0);
        @(posedge clock);
        #1 reset = 1'b0;
        push_fill(16'h0260);
        access(1'b0, 16'h0261, 8'h00, 8'hD2, 5);
        push_fill(16'h0090);
        access(1'b0, 16'h0091, 8'h00, 8'h22, 5);

        repeat (2) @(posedge clock);
        chk("cpu_q_left", cpu_q.size(), 0);
        chk("beat_q_left", beat_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
